// File: rtl/pkt_injector.sv
`default_nettype none
// ============================================================================
// Module   : pkt_injector
// Purpose  : Packetises a descriptor plus buffered payload into a
//            header/size/payload flit stream for a router local port.
//            Optional statistics via `define PKT_INJECTOR_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_injector #(
  parameter int ADDRESS    = 0,
  parameter int FLIT_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [FLIT_WIDTH-1:0] cmd_dest,
  input  logic [FLIT_WIDTH-1:0] cmd_len,
  input  logic                  wr_en,
  input  logic [FLIT_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  clock_tx,
  output logic                  tx,
  output logic [FLIT_WIDTH-1:0] data_o,
  input  logic                  credit_i,
  output logic                  busy
`ifdef PKT_INJECTOR_STATS_EN
  ,
  output logic [31:0]           pkt_count,
  output logic [31:0]           stall_count
`endif
);

  localparam int c_aw = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    SIZE    = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [FLIT_WIDTH-1:0] r_dest;
  logic [FLIT_WIDTH-1:0] r_len;
  logic [FLIT_WIDTH-1:0] r_remaining;
  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]         r_wptr;
  logic [c_aw:0]         r_rptr;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_done;

  // Extra pointer bit separates full (same slot, other lap) from empty.
  assign w_empty  = (r_wptr == r_rptr);
  assign full     = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                    (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
  assign w_push   = wr_en && !full;
  assign w_pop    = (r_state == PAYLOAD) && tx && credit_i;
  assign w_accept = cmd_valid && cmd_ready;
  assign busy     = (r_state != IDLE);
  assign clock_tx = clock;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    tx        = 1'b0;
    data_o    = '0;
    cmd_ready = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid && !reset) begin
          w_next = HEADER;
        end
      end
      HEADER: begin
        tx     = 1'b1;
        data_o = r_dest;
        if (credit_i) begin
          w_next = SIZE;
        end
      end
      SIZE: begin
        tx     = 1'b1;
        data_o = r_len;
        if (credit_i) begin
          w_done = (r_len == '0);
          w_next = (r_len == '0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        // An empty FIFO is a bubble: hold state, drop tx, wait for data.
        tx     = !w_empty;
        data_o = r_mem[r_rptr[c_aw-1:0]];
        if (w_pop && (r_remaining == FLIT_WIDTH'(1))) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dest      <= '0;
      r_len       <= '0;
      r_remaining <= '0;
    end else begin
      if (w_accept) begin
        r_dest <= cmd_dest;
        r_len  <= cmd_len;
      end
      if ((r_state == SIZE) && credit_i) begin
        r_remaining <= r_len;
      end else if (w_pop) begin
        r_remaining <= r_remaining - FLIT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr[c_aw-1:0]] <= wr_data;
    end
  end

`ifdef PKT_INJECTOR_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (w_done) begin
        pkt_count <= pkt_count + 32'd1;
      end
      if (tx && !credit_i) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_done) begin
      $display("pkt_injector x=%0d y=%0d: packet complete",
               ADDRESS[7:0], ADDRESS[15:8]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pkt_injector.sv
`default_nettype none
// Bench for pkt_injector: queue-based reference of the flit stream checked
// every cycle, plus directed scenarios with literal expected sequences.
module tb_pkt_injector;

  localparam int FW    = 16;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [FW-1:0] cmd_dest;
  logic [FW-1:0] cmd_len;
  logic          wr_en;
  logic [FW-1:0] wr_data;
  logic          full;
  logic          clock_tx;
  logic          tx;
  logic [FW-1:0] data_o;
  logic          credit_i;
  logic          busy;
`ifdef PKT_INJECTOR_STATS_EN
  logic [31:0]   pkt_count;
  logic [31:0]   stall_count;
`endif

  pkt_injector #(.ADDRESS(16'h0201), .FLIT_WIDTH(FW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dest(cmd_dest), .cmd_len(cmd_len),
    .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .clock_tx(clock_tx), .tx(tx), .data_o(data_o),
    .credit_i(credit_i), .busy(busy)
`ifdef PKT_INJECTOR_STATS_EN
    , .pkt_count(pkt_count), .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what is still owed to the router, as flit queues.
  logic [FW-1:0] m_fifo[$];
  logic [FW-1:0] m_hdr[$];
  int            m_pay = 0;

  function automatic logic m_busy();
    return (m_hdr.size() > 0) || (m_pay > 0);
  endfunction

  function automatic logic m_tx();
    if (m_hdr.size() > 0) return 1'b1;
    if (m_pay > 0) return (m_fifo.size() > 0);
    return 1'b0;
  endfunction

  function automatic logic [FW-1:0] m_data();
    if (m_hdr.size() > 0) return m_hdr[0];
    return m_fifo[0];
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_fifo.delete();
      m_hdr.delete();
      m_pay = 0;
    end else begin
      logic xfer, wr_ok, acc;
      xfer  = m_tx() && credit_i;
      wr_ok = wr_en && (m_fifo.size() < DEPTH);
      acc   = cmd_valid && !m_busy();
      if (xfer) begin
        if (m_hdr.size() > 0) begin
          void'(m_hdr.pop_front());
        end else begin
          void'(m_fifo.pop_front());
          m_pay--;
        end
      end
      if (wr_ok) m_fifo.push_back(wr_data);
      if (acc) begin
        m_hdr.push_back(cmd_dest);
        m_hdr.push_back(cmd_len);
        m_pay = int'(cmd_len);
      end
    end
  end

  always @(posedge clock) cyc++;

  // Observed transfers, for the literal sequence checks.
  logic [FW-1:0] log_d[$];
  int            log_t[$];

  always @(negedge clock) begin
    if (!reset) begin
      check("busy", busy, m_busy());
      check("cmd_ready", cmd_ready, !m_busy());
      check("full", full, m_fifo.size() == DEPTH);
      check("tx", tx, m_tx());
      if (m_tx()) check("data_o", data_o, m_data());
      if (tx && credit_i) begin
        log_d.push_back(data_o);
        log_t.push_back(cyc);
      end
    end
  end

  task automatic push(input logic [FW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clock); #2;
    wr_en   = 1'b0;
  endtask

  task automatic send_cmd(input logic [FW-1:0] dest, input logic [FW-1:0] len);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_dest  = dest;
    cmd_len   = len;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (cmd_ready) begin ok = 1; break; end
    end
    check("cmd_accept_timeout", ok, 1'b1);
    @(posedge clock); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!busy) begin ok = 1; break; end
    end
    check("idle_timeout", ok, 1'b1);
    @(posedge clock); #2;
  endtask

  task automatic check_log(input string name, input logic [FW-1:0] exp[$], input bit consec);
    check({name, "_len"}, log_d.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_d.size(); i++) begin
      check($sformatf("%s_flit%0d", name, i), log_d[i], exp[i]);
      if (consec) check($sformatf("%s_cyc%0d", name, i), log_t[i] - log_t[0], i);
    end
    log_d.delete();
    log_t.delete();
  endtask

  initial begin
    logic [FW-1:0] exp[$];
`ifdef PKT_INJECTOR_STATS_EN
    logic [31:0] stall0;
`endif
    reset = 1'b1; cmd_valid = 1'b0; cmd_dest = '0; cmd_len = '0;
    wr_en = 1'b0; wr_data = '0; credit_i = 1'b1;
    #1;
    check("rst_tx", tx, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_data", data_o, 16'h0000);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock); #2;

    // Basic packet, back-to-back flits.
    push(16'hA0A0); push(16'hB1B1); push(16'hC2C2);
    send_cmd(16'h0101, 16'd3);
    wait_idle();
    exp = '{16'h0101, 16'h0003, 16'hA0A0, 16'hB1B1, 16'hC2C2};
    check_log("basic", exp, 1);

    // Zero-length packet leaves the FIFO alone.
    push(16'hD3D3);
    send_cmd(16'h0002, 16'd0);
    wait_idle();
    exp = '{16'h0002, 16'h0000};
    check_log("len0", exp, 1);
    send_cmd(16'h0404, 16'd1);
    wait_idle();
    exp = '{16'h0404, 16'h0001, 16'hD3D3};
    check_log("after_len0", exp, 1);

    // Credit withheld during SIZE.
`ifdef PKT_INJECTOR_STATS_EN
    stall0 = stall_count;
`endif
    push(16'h5555);
    send_cmd(16'h0303, 16'd1);
    @(posedge clock); #2;
    credit_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("stall_tx", tx, 1'b1);
      check("stall_data", data_o, 16'h0001);
    end
    @(posedge clock); #2;
    credit_i = 1'b1;
    wait_idle();
    exp = '{16'h0303, 16'h0001, 16'h5555};
    check_log("stall", exp, 0);
`ifdef PKT_INJECTOR_STATS_EN
    check("stall_count", stall_count - stall0, 32'd4);
`endif

    // Payload bubble while FIFO runs dry.
    push(16'h1111); push(16'h2222);
    send_cmd(16'h0606, 16'd4);
    repeat (6) @(posedge clock);
    #2;
    @(negedge clock);
    check("bubble_tx", tx, 1'b0);
    check("bubble_busy", busy, 1'b1);
    @(posedge clock); #2;
    push(16'h3333);
    repeat (3) @(posedge clock);
    #2;
    push(16'h4444);
    wait_idle();
    exp = '{16'h0606, 16'h0004, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    check_log("bubble", exp, 0);

    // Overfill: the 17th write is dropped.
    for (int i = 0; i < DEPTH + 1; i++) push(FW'(16'hF000 + i));
    @(negedge clock);
    check("overfill_full", full, 1'b1);
    @(posedge clock); #2;
    send_cmd(16'h0707, 16'd16);
    wait_idle();
    exp = '{16'h0707, 16'h0010};
    for (int i = 0; i < DEPTH; i++) exp.push_back(FW'(16'hF000 + i));
    check_log("overfill", exp, 1);
    check("drained_full", full, 1'b0);

    // Reset in the middle of a payload.
    push(16'hE0E0); push(16'hE1E1); push(16'hE2E2);
    send_cmd(16'h0808, 16'd3);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data", data_o, 16'h0000);
    check("midrst_ready", cmd_ready, 1'b0);
    check("midrst_full", full, 1'b0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    log_d.delete();
    log_t.delete();
    push(16'h9999);
    send_cmd(16'h0505, 16'd1);
    wait_idle();
    exp = '{16'h0505, 16'h0001, 16'h9999};
    check_log("post_reset", exp, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
